// File: rtl/seven_seg_scan.sv
// N-digit multiplexed seven-segment scanner with shadow register, PWM brightness and per-digit dp.
// Optional leading-zero blanking is compiled in with `define SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV_WIDTH      = 10,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   din,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  input  logic [3:0]                bright,
  input  logic                      blank_en,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     digit_sel,
  output logic                      frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_MASK = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] SEL_MASK =
    (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [DIV_WIDTH-1:0]    div_cnt_reg, div_cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [4*NUM_DIGITS-1:0] shadow_din_reg, shadow_din_next;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg, shadow_dp_next;
  logic [6:0]              seg_reg, seg_next;
  logic                    dp_reg, dp_next;
  logic [NUM_DIGITS-1:0]   sel_reg, sel_next;
  logic                    frame_done_reg, frame_done_next;

  logic                    tick;
  logic                    on;
  logic                    blank_cur;
  logic [3:0]              nib [NUM_DIGITS];

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nib[gi] = shadow_din_reg[4*gi +: 4];
    end
  endgenerate

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
  logic [NUM_DIGITS-1:0] lz_mask;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_first
        assign lz_mask[gi] = 1'b0;
      end else begin : g_upper
        assign lz_mask[gi] = (shadow_din_reg[4*NUM_DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate
  assign blank_cur = blank_en & lz_mask[idx_reg];
`else
  logic unused_blank_en;
  assign unused_blank_en = blank_en;
  assign blank_cur = 1'b0;
`endif

  assign tick = &div_cnt_reg;
  assign on   = (div_cnt_reg[DIV_WIDTH-1 -: 4] <= bright);

  always_comb begin
    div_cnt_next    = div_cnt_reg + DIV_WIDTH'(1);
    idx_next        = idx_reg;
    shadow_din_next = shadow_din_reg;
    shadow_dp_next  = shadow_dp_reg;
    seg_next        = SEG_MASK;
    dp_next         = DP_MASK;
    sel_next        = SEL_MASK;
    frame_done_next = tick && (idx_reg == LAST_IDX);

    if (tick) begin
      idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
    end
    if (load) begin
      shadow_din_next = din;
      shadow_dp_next  = dp_in;
    end

    // Outputs are built from the current (pre-edge) shadow, so a load shows one cycle later.
    if (on) begin
      seg_next = (blank_cur ? 7'h00 : hex_to_seg(nib[idx_reg])) ^ SEG_MASK;
      dp_next  = shadow_dp_reg[idx_reg] ^ DP_MASK;
      sel_next = ({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_reg) ^ SEL_MASK;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      div_cnt_reg    <= '0;
      idx_reg        <= '0;
      shadow_din_reg <= '0;
      shadow_dp_reg  <= '0;
      seg_reg        <= SEG_MASK;
      dp_reg         <= DP_MASK;
      sel_reg        <= SEL_MASK;
      frame_done_reg <= 1'b0;
    end else begin
      div_cnt_reg    <= div_cnt_next;
      idx_reg        <= idx_next;
      shadow_din_reg <= shadow_din_next;
      shadow_dp_reg  <= shadow_dp_next;
      seg_reg        <= seg_next;
      dp_reg         <= dp_next;
      sel_reg        <= sel_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign digit_sel  = sel_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (NUM_DIGITS=4, DIV_WIDTH=4) against a cycle-count reference model.
module tb_seven_seg_scan;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] din = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [3:0]  bright = 4'hF;
  logic        blank_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int checks = 0;
  int passed = 0;

  // Reference model state: edges since reset release and the shadowed display data.
  int          cyc = 0;
  logic [15:0] m_din = '0;
  logic [3:0]  m_dp = '0;
  logic [12:0] exp_vec = '0;
  logic [6:0]  seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 CLK = ~CLK;

  seven_seg_scan #(
    .NUM_DIGITS(4),
    .DIV_WIDTH(4),
    .SEG_ACTIVE_LOW(1),
    .SEL_ACTIVE_LOW(0)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .din(din),
    .dp_in(dp_in),
    .load(load),
    .bright(bright),
    .blank_en(blank_en),
    .seg(seg),
    .dp(dp),
    .digit_sel(digit_sel),
    .frame_done(frame_done)
  );

  // Expected {seg, dp, digit_sel, frame_done} registered at the edge that follows state c.
  function automatic logic [12:0] model_out(input int c, input logic [15:0] d,
                                            input logic [3:0] dpv, input logic [3:0] br);
    int         dv;
    int         ix;
    logic       fd;
    logic       blanked;
    logic [15:0] upper;
    logic [6:0] segv;
    dv = c % 16;
    ix = (c / 16) % 4;
    fd = ((c % 64) == 63);
    upper = d >> (4 * ix);
    blanked = 1'b0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
    blanked = blank_en && (ix > 0) && (upper == 16'h0000);
`endif
    segv = blanked ? 7'h00 : seg_tbl[upper[3:0]];
    if (dv > int'(br)) return {7'h7F, 1'b1, 4'b0000, fd};
    return {~segv, ~dpv[ix], 4'b0001 << ix, fd};
  endfunction

  task automatic step();
    @(posedge CLK);
    exp_vec = model_out(cyc, m_din, m_dp, bright);
    if (load) begin
      m_din = din;
      m_dp  = dp_in;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({seg, dp, digit_sel, frame_done} !== {7'h7F, 1'b1, 4'b0000, 1'b0})
      $display("FAIL reset_hold seg=%h dp=%b sel=%b fd=%b want seg=7f dp=1 sel=0000 fd=0",
               seg, dp, digit_sel, frame_done);
    else passed++;
    reset = 1'b0;
    cyc = 0; m_din = '0; m_dp = '0;
    step();
    checks++;
    if (digit_sel !== 4'b0001) $display("FAIL first_sel got=%b want=0001", digit_sel);
    else passed++;
    checks++;
    if ({seg, dp, digit_sel, frame_done} !== exp_vec)
      $display("FAIL first_cycle got=%h want=%h", {seg, dp, digit_sel, frame_done}, exp_vec);
    else passed++;
    $display("reset: released, first sel=%b seg=%h", digit_sel, seg);
  endtask

  task automatic test_scan();
    logic [6:0] seen [4];
    int fd_cnt = 0;
    int hold [4] = '{0, 0, 0, 0};
    logic [6:0] want [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    bright = 4'hF; din = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 128; i++) begin
      step();
      checks++;
      if ({seg, dp, digit_sel, frame_done} !== exp_vec)
        $display("FAIL scan cyc=%0d got=%h want=%h", cyc, {seg, dp, digit_sel, frame_done}, exp_vec);
      else passed++;
      if (frame_done) fd_cnt++;
      for (int d = 0; d < 4; d++) begin
        if (digit_sel == (4'b0001 << d)) begin
          seen[d] = seg;
          if (i >= 64) hold[d]++;
        end
      end
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (seen[d] !== want[d]) $display("FAIL scan_seg d=%0d got=%h want=%h", d, seen[d], want[d]);
      else passed++;
      checks++;
      if (hold[d] != 16) $display("FAIL scan_hold d=%0d got=%0d want=16", d, hold[d]);
      else passed++;
    end
    checks++;
    if (fd_cnt != 2) $display("FAIL frame_done_count got=%0d want=2", fd_cnt);
    else passed++;
    $display("scan: din=1234 frame_done pulses=%0d in 128 cycles", fd_cnt);
  endtask

  task automatic test_brightness();
    logic [3:0] levels [4];
    levels[0] = 4'd3;
    levels[1] = 4'd0;
    levels[2] = 4'($urandom_range(0, 15));
    levels[3] = 4'($urandom_range(0, 15));
    for (int l = 0; l < 4; l++) begin
      int act [4] = '{0, 0, 0, 0};
      bright = levels[l];
      din = 16'($urandom); load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 64; i++) begin
        step();
        checks++;
        if ({seg, dp, digit_sel, frame_done} !== exp_vec)
          $display("FAIL bright cyc=%0d got=%h want=%h", cyc, {seg, dp, digit_sel, frame_done}, exp_vec);
        else passed++;
        for (int d = 0; d < 4; d++) if (digit_sel[d]) act[d]++;
      end
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (act[d] != int'(levels[l]) + 1)
          $display("FAIL bright_duty lvl=%0d d=%0d got=%0d want=%0d", levels[l], d, act[d], levels[l] + 1);
        else passed++;
      end
      $display("bright: level=%0d din=%h duty=%0d/16", levels[l], din, act[0]);
    end
    bright = 4'hF;
  endtask

  task automatic test_dp();
    int low_ok = 0;
    dp_in = 4'b0100; din = 16'h9876; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      checks++;
      if ({seg, dp, digit_sel, frame_done} !== exp_vec)
        $display("FAIL dp cyc=%0d got=%h want=%h", cyc, {seg, dp, digit_sel, frame_done}, exp_vec);
      else passed++;
      if (dp == 1'b0 && digit_sel == 4'b0100) low_ok++;
    end
    checks++;
    if (low_ok != 16) $display("FAIL dp_low got=%0d want=16", low_ok);
    else passed++;
    $display("dp: dp_in=0100 low cycles on digit 2=%0d", low_ok);
    dp_in = 4'b0000;
  endtask

  task automatic test_load_tick();
    int ix;
    logic [15:0] nd;
    bright = 4'hF;
    for (int i = 0; i < 16 && (cyc % 16) != 15; i++) begin
      step();
      checks++;
      if ({seg, dp, digit_sel, frame_done} !== exp_vec)
        $display("FAIL align cyc=%0d got=%h want=%h", cyc, {seg, dp, digit_sel, frame_done}, exp_vec);
      else passed++;
    end
    nd = 16'($urandom);
    din = nd; load = 1'b1;
    step();
    load = 1'b0;
    ix = (cyc / 16) % 4;
    step();
    nd = nd >> (4 * ix);
    checks++;
    if (seg !== ~seg_tbl[nd[3:0]] || digit_sel !== (4'b0001 << ix))
      $display("FAIL load_tick seg=%h sel=%b want seg=%h sel=%b", seg, digit_sel, ~seg_tbl[nd[3:0]], 4'b0001 << ix);
    else passed++;
    $display("load_tick: din=%h shown on digit %0d seg=%h", din, ix, seg);
  endtask

  task automatic test_blank();
    logic [15:0] pats [2] = '{16'h0050, 16'h0000};
    blank_en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      din = pats[p]; load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 65; i++) begin
        step();
        checks++;
        if ({seg, dp, digit_sel, frame_done} !== exp_vec)
          $display("FAIL blank din=%h cyc=%0d got=%h want=%h", pats[p], cyc, {seg, dp, digit_sel, frame_done}, exp_vec);
        else passed++;
      end
      $display("blank: din=%h blank_en=1", pats[p]);
    end
    blank_en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 7) == 0);
      din = 16'($urandom);
      dp_in = 4'($urandom);
      if ($urandom_range(0, 31) == 0) bright = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_en = 1'($urandom);
      step();
      checks++;
      if ({seg, dp, digit_sel, frame_done} !== exp_vec)
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, {seg, dp, digit_sel, frame_done}, exp_vec);
      else passed++;
    end
    load = 1'b0; blank_en = 1'b0; bright = 4'hF; dp_in = 4'b0000;
    $display("random: 400 cycles, last shadow=%h", m_din);
  endtask

  task automatic test_async_reset();
    din = 16'hABCD; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 80 && exp_vec[4:1] != 4'b0100; i++) begin
      step();
      checks++;
      if ({seg, dp, digit_sel, frame_done} !== exp_vec)
        $display("FAIL pre_reset cyc=%0d got=%h want=%h", cyc, {seg, dp, digit_sel, frame_done}, exp_vec);
      else passed++;
    end
    checks++;
    if (digit_sel !== 4'b0100) $display("FAIL pre_reset_sel got=%b want=0100", digit_sel);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({seg, dp, digit_sel, frame_done} !== {7'h7F, 1'b1, 4'b0000, 1'b0})
      $display("FAIL async_reset seg=%h dp=%b sel=%b fd=%b want seg=7f dp=1 sel=0000 fd=0",
               seg, dp, digit_sel, frame_done);
    else passed++;
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;
    cyc = 0; m_din = '0; m_dp = '0;
    step();
    checks++;
    if (digit_sel !== 4'b0001 || seg !== 7'h40)
      $display("FAIL restart sel=%b seg=%h want sel=0001 seg=40", digit_sel, seg);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({seg, dp, digit_sel, frame_done} !== exp_vec)
        $display("FAIL post_reset cyc=%0d got=%h want=%h", cyc, {seg, dp, digit_sel, frame_done}, exp_vec);
      else passed++;
    end
    $display("async_reset: outputs cleared mid-cycle, scan restarted at digit 0");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_brightness();
    test_dp();
    test_load_tick();
    test_blank();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Parametrised N-digit multiplexed seven-segment scanner; successor to the fixed 2-digit controller.
- Takes a packed hex word, latches it into a shadow register on a load strobe, and time-multiplexes digits with a one-hot select.
- Adds PWM brightness, per-digit decimal points, a frame-done pulse and optional leading-zero blanking.
- Sits between the core's debug/PC bus and the Pmod display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (>=2).
- DIV_WIDTH, 10: refresh divider width (>=4); each digit is held for 2^DIV_WIDTH cycles.
- SEG_ACTIVE_LOW, 1: 1 inverts seg and dp outputs.
- SEL_ACTIVE_LOW, 0: 1 inverts digit_sel.

Ports:
- CLK  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- din  in  4*NUM_DIGITS  hex nibbles; [3:0] is digit 0 (rightmost).
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- load  in  1  shadow-register load strobe.
- bright  in  4  brightness, 0..15 (15 = full on).
- blank_en  in  1  leading-zero blanking enable.
- seg  out  7  segments; bit0 = a … bit6 = g.
- dp  out  1  decimal point.
- digit_sel  out  NUM_DIGITS  one-hot digit select.
- frame_done  out  1  one-cycle pulse at end of each full scan.

Behaviour:
- Reset (async, active-high):
  - Clears div_cnt, idx, shadow_din and shadow_dp to 0.
  - Outputs go inactive immediately: seg all off, dp off, digit_sel none, frame_done 0. "Off" and "none" are taken after the polarity parameters are applied.
- Shadow register: shadow_din and shadow_dp update on the edge where load=1. The display never reads din directly.
- Divider:
  - div_cnt increments every cycle and wraps from 2^DIV_WIDTH-1 to 0.
  - tick = (div_cnt == all ones).
- Scan index idx:
  - On tick, idx advances and wraps from NUM_DIGITS-1 to 0.
  - frame_done is registered high for exactly one cycle when tick && idx==NUM_DIGITS-1.
- Decoder map (before polarity): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71.
- Brightness:
  - on = (div_cnt[DIV_WIDTH-1 -: 4] <= bright).
  - When on=0, seg, dp and digit_sel are all inactive.
- Output register: seg, dp and digit_sel are registered every cycle from the current idx, shadow and on. Output reflects state with 1-cycle latency.
- Simultaneous load and tick: both take effect; the new data is shown on the following cycle.
- A load mid-digit changes that digit's segments on the next cycle; there is no scan restart.

Optional Feature:
- Macro: SEVEN_SEG_LZ_BLANK_EN.
- Defined, with blank_en=1:
  - Scanning from the top digit down, each digit whose nibble is 0 is blanked (seg off) until the first nonzero nibble.
  - Digit 0 is never blanked.
  - dp of a blanked digit is still driven from shadow_dp.
  - digit_sel still asserts for a blanked digit.
- Not defined: blank_en is ignored and all digits always display.

Test Plan (NUM_DIGITS=4, DIV_WIDTH=4, defaults otherwise):
- Reset held, then released → seg=7'h7F, dp=1 and digit_sel=4'b0000 during reset. First edge after release → digit_sel=4'b0001.
- load=1 with din=16'h1234, bright=15 → digit_sel goes 0001→0010→0100→1000, each held 16 cycles. seg values are 7'h19 (4), 7'h30 (3), 7'h24 (2), 7'h79 (1). frame_done pulses once every 64 cycles.
- bright=3 → for each digit, digit_sel is active for exactly 4 of 16 cycles, at div_cnt 0..3 (seen 1 cycle later). bright=0 → 1 of 16 cycles.
- dp_in=4'b0100 → dp=0 only while digit_sel=4'b0100. load=1 and tick in the same cycle → new data appears on the next cycle.
- With SEVEN_SEG_LZ_BLANK_EN and blank_en=1:
  - din=16'h0050 → digits 3 and 2 show seg=7'h7F, digit 1 shows 7'h12, digit 0 shows 7'h40.
  - din=16'h0000 → only digit 0 shows 7'h40.
  - Without the macro, din=16'h0050 → all four digits display.
- Assert reset while digit_sel=4'b0100 → outputs go inactive in the same cycle, before any clock edge. After release, the display shows 0 (shadow cleared) and the scan restarts at digit 0.
